// File: rtl/microwave_ctrl_if.sv
// Signal bundle between the microwave sequencer and its surroundings (panel, timer, loads).
// master = panel/timer/load side, slave = the sequencer itself.
interface microwave_ctrl_if;
    logic       door_open;
    logic       btn_start;
    logic       btn_stop;
    logic       btn_pause;
    logic [1:0] sel;
    logic [6:0] sw_min;
    logic [6:0] sw_sec;
    logic       timer_done;
    logic       tim_start;
    logic       tim_stop;
    logic       tim_pause;
    logic [6:0] min;
    logic [6:0] sec;
    logic       magnetron;
    logic       lamp;
    logic       beep;
    logic [2:0] state;

    modport master (
        output door_open, btn_start, btn_stop, btn_pause, sel, sw_min, sw_sec, timer_done,
        input  tim_start, tim_stop, tim_pause, min, sec, magnetron, lamp, beep, state
    );

    modport slave (
        input  door_open, btn_start, btn_stop, btn_pause, sel, sw_min, sw_sec, timer_done,
        output tim_start, tim_stop, tim_pause, min, sec, magnetron, lamp, beep, state
    );
endinterface

// File: rtl/microwave_ctrl.sv
// Microwave sequencer: picks cook time, pulses the countdown timer, drives magnetron/lamp/beeper.
// All outputs registered (1-clock latency from inputs); door interlock and stop always win.
module microwave_ctrl #(
    parameter int BEEP_CYCLES = 300_000_000,
    parameter int ARM_TIMEOUT = 16
) (
    input  logic               clock,
    input  logic               reset,
    microwave_ctrl_if.slave    io
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_COOK  = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    localparam int CNT_MAX = (BEEP_CYCLES > ARM_TIMEOUT) ? BEEP_CYCLES : ARM_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] BEEP_LAST = CW'(BEEP_CYCLES - 1);
    localparam logic [CW-1:0] ARM_LAST  = CW'(ARM_TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          start_prev, stop_prev, pause_prev;
    logic          start_rise, stop_rise, pause_rise;
    logic [6:0]    ld_min, ld_sec;
    logic          ld_nonzero;

    logic          tim_start_q, tim_stop_q, tim_pause_q;
    logic          tim_start_d, tim_stop_d, tim_pause_d;
    logic [6:0]    min_q, sec_q, min_d, sec_d;
    logic          magnetron_q, lamp_q, beep_q;
    logic          magnetron_d, lamp_d, beep_d;

    assign start_rise = io.btn_start & ~start_prev;
    assign stop_rise  = io.btn_stop  & ~stop_prev;
    assign pause_rise = io.btn_pause & ~pause_prev;

    always_comb begin
        ld_min = 7'd0;
        ld_sec = 7'd0;
        case (io.sel)
            2'b00: begin
                ld_min = (io.sw_min > 7'd99) ? 7'd99 : io.sw_min;
                ld_sec = (io.sw_sec > 7'd59) ? 7'd59 : io.sw_sec;
            end
            2'b01: begin ld_min = 7'd2;  ld_sec = 7'd30; end
            2'b10: begin ld_min = 7'd4;  ld_sec = 7'd0;  end
            default: begin ld_min = 7'd10; ld_sec = 7'd0; end
        endcase
        ld_nonzero = (ld_min != 7'd0) || (ld_sec != 7'd0);
    end

    // State register plus the edge-detect history and shared dwell counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            start_prev <= 1'b1;
            stop_prev  <= 1'b1;
            pause_prev <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            start_prev <= io.btn_start;
            stop_prev  <= io.btn_stop;
            pause_prev <= io.btn_pause;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:
                if (start_rise && !stop_rise && !pause_rise && !io.door_open && ld_nonzero)
                    state_d = S_ARM;
            S_ARM:
                if (stop_rise || io.door_open)  state_d = S_IDLE;
                else if (!io.timer_done)        state_d = S_COOK;
                else if (cnt_q == ARM_LAST)     state_d = S_FAULT;
            S_COOK:
                if (stop_rise)                         state_d = S_IDLE;
                else if (io.door_open || pause_rise)   state_d = S_PAUSE;
                else if (io.timer_done)                state_d = S_DONE;
            S_PAUSE:
                if (stop_rise)                                          state_d = S_IDLE;
                else if (!io.door_open && (pause_rise || start_rise))   state_d = S_COOK;
            S_DONE:
                if (stop_rise || start_rise || cnt_q == BEEP_LAST) state_d = S_IDLE;
            S_FAULT:
                if (stop_rise) state_d = S_IDLE;
            default:
                state_d = S_IDLE;
        endcase
    end

    // Pulses are derived from the transition taken, so at most one can fire per cycle.
    always_comb begin
        cnt_d = '0;
        if ((state_q == S_ARM || state_q == S_DONE) && state_d == state_q)
            cnt_d = cnt_q + 1'b1;

        tim_start_d = ((state_q == S_IDLE) && (state_d == S_ARM)) ||
                      ((state_q == S_PAUSE) && (state_d == S_COOK) && !pause_rise);
        tim_pause_d = ((state_q == S_COOK) && (state_d == S_PAUSE)) ||
                      ((state_q == S_PAUSE) && (state_d == S_COOK) && pause_rise);
        tim_stop_d  = (state_d == S_IDLE) &&
                      (state_q == S_ARM || state_q == S_COOK ||
                       state_q == S_PAUSE || state_q == S_FAULT);

        min_d = (state_q == S_IDLE) ? ld_min : min_q;
        sec_d = (state_q == S_IDLE) ? ld_sec : sec_q;

        magnetron_d = (state_d == S_COOK) && !io.door_open;
        lamp_d      = io.door_open || (state_d == S_ARM) || (state_d == S_COOK);
        beep_d      = (state_d == S_DONE) || (state_d == S_FAULT);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tim_start_q <= 1'b0;
            tim_stop_q  <= 1'b0;
            tim_pause_q <= 1'b0;
            min_q       <= 7'd0;
            sec_q       <= 7'd0;
            magnetron_q <= 1'b0;
            lamp_q      <= 1'b0;
            beep_q      <= 1'b0;
        end else begin
            tim_start_q <= tim_start_d;
            tim_stop_q  <= tim_stop_d;
            tim_pause_q <= tim_pause_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            magnetron_q <= magnetron_d;
            lamp_q      <= lamp_d;
            beep_q      <= beep_d;
        end
    end

    assign io.tim_start = tim_start_q;
    assign io.tim_stop  = tim_stop_q;
    assign io.tim_pause = tim_pause_q;
    assign io.min       = min_q;
    assign io.sec       = sec_q;
    assign io.magnetron = magnetron_q;
    assign io.lamp      = lamp_q;
    assign io.beep      = beep_q;
    assign io.state     = state_q;

endmodule

// File: tb/tb_microwave_ctrl.sv
// Bench for microwave_ctrl: directed scenarios, a rule-level reference model checked every cycle.
module tb_microwave_ctrl;

    localparam int BEEP = 8;
    localparam int ARMT = 16;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    microwave_ctrl_if bus ();

    microwave_ctrl #(.BEEP_CYCLES(BEEP), .ARM_TIMEOUT(ARMT)) dut (
        .clock (clock),
        .reset (reset),
        .io    (bus.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int ts_cnt = 0;
    int tp_cnt = 0;
    int tt_cnt = 0;

    logic tmr_stuck = 1'b0;
    logic tmr_force_idle = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_state(input int s, input int budget, input string name);
        int k = 0;
        while (int'(bus.state) != s && k < budget) begin
            tick();
            k++;
        end
        chk(name, int'(bus.state), s);
    endtask

    task automatic press_start();
        bus.btn_start = 1'b1;
        tick();
        bus.btn_start = 1'b0;
    endtask

    // Countdown timer stand-in: idle drops 3 clocks after a start, stop makes it idle again.
    int tmr_cd = 0;
    initial begin
        bus.timer_done = 1'b1;
        forever begin
            @(posedge clock);
            #2;
            if (!reset) begin
                bus.timer_done = 1'b1;
                tmr_cd = 0;
            end else if (tmr_force_idle || bus.tim_stop) begin
                bus.timer_done = 1'b1;
                tmr_cd = 0;
            end else begin
                if (bus.tim_start && !tmr_stuck) tmr_cd = 3;
                if (tmr_cd > 0) begin
                    tmr_cd--;
                    if (tmr_cd == 0) bus.timer_done = 1'b0;
                end
            end
        end
    end

    // Reference model: states by number, beep and arm windows as remaining-cycle budgets.
    int m_state, m_min, m_sec, m_ts, m_tp, m_tt, m_mag, m_lamp, m_beep;
    int beep_left, arm_left;
    bit p_start, p_stop, p_pause;
    int pre_min [4] = '{0, 2, 4, 10};
    int pre_sec [4] = '{0, 30, 0, 0};

    initial begin
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                m_state = 0; m_min = 0; m_sec = 0; m_ts = 0; m_tp = 0; m_tt = 0;
                m_mag = 0; m_lamp = 0; m_beep = 0; beep_left = 0; arm_left = 0;
                p_start = 1; p_stop = 1; p_pause = 1;
            end else begin
                bit rs, rt, rp, dr;
                int nxt, lm, lsec;
                rs = bus.btn_start && !p_start;
                rt = bus.btn_stop  && !p_stop;
                rp = bus.btn_pause && !p_pause;
                dr = bus.door_open;
                p_start = bus.btn_start; p_stop = bus.btn_stop; p_pause = bus.btn_pause;
                m_ts = 0; m_tp = 0; m_tt = 0;
                nxt = m_state;
                if (bus.sel == 2'b00) begin
                    lm   = (int'(bus.sw_min) > 99) ? 99 : int'(bus.sw_min);
                    lsec = (int'(bus.sw_sec) > 59) ? 59 : int'(bus.sw_sec);
                end else begin
                    lm   = pre_min[bus.sel];
                    lsec = pre_sec[bus.sel];
                end
                case (m_state)
                    0: begin
                        m_min = lm; m_sec = lsec;
                        if (rs && !rt && !rp && !dr && (lm + lsec) != 0) begin
                            nxt = 1; m_ts = 1; arm_left = ARMT;
                        end
                    end
                    1: if (rt || dr) begin nxt = 0; m_tt = 1; end
                       else if (!bus.timer_done) nxt = 2;
                       else begin
                           arm_left--;
                           if (arm_left == 0) nxt = 5;
                       end
                    2: if (rt) begin nxt = 0; m_tt = 1; end
                       else if (dr || rp) begin nxt = 3; m_tp = 1; end
                       else if (bus.timer_done) begin nxt = 4; beep_left = BEEP; end
                    3: if (rt) begin nxt = 0; m_tt = 1; end
                       else if (!dr && rp) begin nxt = 2; m_tp = 1; end
                       else if (!dr && rs) begin nxt = 2; m_ts = 1; end
                    4: if (rt || rs) nxt = 0;
                       else begin
                           beep_left--;
                           if (beep_left == 0) nxt = 0;
                       end
                    5: if (rt) begin nxt = 0; m_tt = 1; end
                    default: nxt = 0;
                endcase
                m_state = nxt;
                m_mag  = (nxt == 2 && !dr) ? 1 : 0;
                m_lamp = (dr || nxt == 1 || nxt == 2) ? 1 : 0;
                m_beep = (nxt == 4 || nxt == 5) ? 1 : 0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            chk("state",     int'(bus.state),     m_state);
            chk("tim_start", int'(bus.tim_start), m_ts);
            chk("tim_pause", int'(bus.tim_pause), m_tp);
            chk("tim_stop",  int'(bus.tim_stop),  m_tt);
            chk("min",       int'(bus.min),       m_min);
            chk("sec",       int'(bus.sec),       m_sec);
            chk("magnetron", int'(bus.magnetron), m_mag);
            chk("lamp",      int'(bus.lamp),      m_lamp);
            chk("beep",      int'(bus.beep),      m_beep);
            chk("pulse_excl", (int'(bus.tim_start) + int'(bus.tim_pause) + int'(bus.tim_stop)) <= 1, 1);
            ts_cnt += int'(bus.tim_start);
            tp_cnt += int'(bus.tim_pause);
            tt_cnt += int'(bus.tim_stop);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, ts0, tp0, tt0;
        reset = 1'b0;
        bus.door_open = 1'b0; bus.btn_start = 1'b0; bus.btn_stop = 1'b0; bus.btn_pause = 1'b0;
        bus.sel = 2'b00; bus.sw_min = 7'd1; bus.sw_sec = 7'd5;
        tick(3);
        chk("rst_state", int'(bus.state), 0);
        chk("rst_min", int'(bus.min), 0);
        chk("rst_outs", int'({bus.tim_start, bus.tim_stop, bus.tim_pause, bus.magnetron, bus.lamp, bus.beep}), 0);
        reset = 1'b1;
        tick(2);

        // 1: manual 1:05 start
        chk("t1_min", int'(bus.min), 1);
        chk("t1_sec", int'(bus.sec), 5);
        press_start();
        chk("t1_arm", int'(bus.state), 1);
        chk("t1_tim_start", int'(bus.tim_start), 1);
        tick();
        chk("t1_start_1clk", int'(bus.tim_start), 0);
        wait_state(2, 20, "t1_cook");
        chk("t1_magnetron", int'(bus.magnetron), 1);
        chk("t1_lamp", int'(bus.lamp), 1);
        chk("t1_start_count", ts_cnt, 1);

        // 2: door open pauses, start ignored while open, resume
        bus.door_open = 1'b1;
        tick();
        chk("t2_pause", int'(bus.state), 3);
        chk("t2_tim_pause", int'(bus.tim_pause), 1);
        chk("t2_mag_off", int'(bus.magnetron), 0);
        tick();
        ts0 = ts_cnt;
        press_start();
        tick();
        chk("t2_ignored_state", int'(bus.state), 3);
        chk("t2_ignored_pulse", ts_cnt, ts0);
        bus.door_open = 1'b0;
        tick(2);
        press_start();
        chk("t2_resume", int'(bus.state), 2);
        chk("t2_resume_pulse", int'(bus.tim_start), 1);
        tick();
        chk("t2_mag_on", int'(bus.magnetron), 1);

        // 3: timer finishes -> beep exactly BEEP clocks
        tmr_force_idle = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.beep) n++;
            if (bus.state == 3'd0 && n > 0) break;
        end
        chk("t3_beep_len", n, 8);
        chk("t3_idle", int'(bus.state), 0);
        chk("t3_beep_off", int'(bus.beep), 0);
        tmr_force_idle = 1'b0;
        tick();

        // 4: stop and pause together in COOK -> only stop
        press_start();
        wait_state(2, 20, "t4_cook");
        tp0 = tp_cnt;
        bus.btn_stop = 1'b1; bus.btn_pause = 1'b1;
        tick();
        chk("t4_tim_stop", int'(bus.tim_stop), 1);
        chk("t4_no_pause", tp_cnt, tp0);
        chk("t4_idle", int'(bus.state), 0);
        bus.btn_stop = 1'b0; bus.btn_pause = 1'b0;
        tick(2);

        // 5: timer never leaves idle -> FAULT after ARM_TIMEOUT clocks
        tmr_stuck = 1'b1;
        press_start();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.state == 3'd1) n++;
            if (bus.state == 3'd5) break;
            tick();
        end
        chk("t5_arm_len", n, 16);
        chk("t5_fault", int'(bus.state), 5);
        chk("t5_beep", int'(bus.beep), 1);
        chk("t5_mag", int'(bus.magnetron), 0);
        tt0 = tt_cnt;
        bus.btn_stop = 1'b1;
        tick();
        chk("t5_tim_stop", int'(bus.tim_stop), 1);
        chk("t5_idle", int'(bus.state), 0);
        chk("t5_stop_count", tt_cnt, tt0 + 1);
        bus.btn_stop = 1'b0;
        tmr_stuck = 1'b0;
        tick(2);

        // 6: presets, clamping, zero time, reset mid-cook
        bus.sel = 2'b10;
        tick();
        chk("t6_pizza_min", int'(bus.min), 4);
        chk("t6_pizza_sec", int'(bus.sec), 0);
        bus.sel = 2'b11;
        tick();
        chk("t6_defrost_min", int'(bus.min), 10);
        bus.sel = 2'b00; bus.sw_min = 7'd0; bus.sw_sec = 7'd75;
        tick();
        chk("t6_clamp_sec", int'(bus.sec), 59);
        bus.sw_min = 7'd120;
        tick();
        chk("t6_clamp_min", int'(bus.min), 99);
        bus.sw_min = 7'd0; bus.sw_sec = 7'd0;
        tick();
        ts0 = ts_cnt;
        press_start();
        tick();
        chk("t6_zero_ignored", int'(bus.state), 0);
        chk("t6_zero_no_pulse", ts_cnt, ts0);
        bus.sw_min = 7'd1; bus.sw_sec = 7'd5;
        tick();
        press_start();
        wait_state(2, 20, "t6_cook");
        reset = 1'b0;
        #1;
        chk("t6_rst_state", int'(bus.state), 0);
        chk("t6_rst_minsec", int'({bus.min, bus.sec}), 0);
        chk("t6_rst_outs", int'({bus.tim_start, bus.tim_stop, bus.tim_pause, bus.magnetron, bus.lamp, bus.beep}), 0);
        bus.btn_start = 1'b1;
        tick(2);
        ts0 = ts_cnt;
        reset = 1'b1;
        tick(3);
        chk("t6_held_btn_no_start", int'(bus.state), 0);
        chk("t6_held_btn_no_pulse", ts_cnt, ts0);
        bus.btn_start = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
